if_fetch_unit: RTL and testbench

- Producer side of the IF/ID pipeline register: owns the PC, issues instruction-memory reads, and drives PC, PC+4, Instruction, IF_ID_Wr and IF_ID_Flush into the IF/ID latch.
- Applies load-use stalls, ID-stage jumps, EX-stage branches and exception redirects.
- Tracks outstanding memory requests so that instructions from a squashed path are never written into IF/ID.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/pc_redirect_mux.sv | 33 +++
 rtl/if_fetch_unit.sv | 216 +++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Purpose : shared fetch-side constants, the fetch FSM state type and a word-alignment helper.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: RESET_PC_DEF / EXC_VECTOR_DEF parameter defaults, NOP_INSN, fetch_state_t, align_word().
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
    localparam logic [31:0] NOP_INSN       = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    // Instruction fetches are word-aligned; low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Purpose : instruction-memory read channel between the fetch unit and the memory.
// Latency : n/a (wires only); data is valid in the same cycle as imem_ready.
// Backpr. : memory stalls by holding imem_ready low; the request stays asserted and stable.
// Signals : imem_req/imem_addr (fetch -> mem), imem_ready/imem_rdata (mem -> fetch).
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Fetch unit side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_redirect_mux.sv
// Purpose : priority select of the redirect target (exception > branch > jump), word-aligned.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_exception, i_branch_taken/i_branch_target, i_jump/i_jump_target -> o_redirect, o_target.
module pc_redirect_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        i_exception,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    logic [31:0] w_raw_target;

    always_comb begin
        w_raw_target = i_jump_target;
        if (i_exception) begin
            w_raw_target = EXC_VECTOR;
        end else if (i_branch_taken) begin
            w_raw_target = i_branch_target;
        end
    end

    assign o_redirect = i_exception | i_branch_taken | i_jump;
    assign o_target   = align_word(w_raw_target);

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose : IF stage - owns the PC, reads instruction memory, writes/flushes the IF/ID register.
// Latency : one instruction per cycle with zero-wait memory (data returned in the request cycle).
// Backpr. : stall holds PC and IF/ID; memory wait holds the request; squashed responses are dropped.
// Ports   : clk, reset (async active-low), stall, jump/jump_target, branch_taken/branch_target,
//           exception, imem (if_fetch_unit_if.master), PC_out, PC_plus4, Instruction, IF_ID_Wr, IF_ID_Flush.
// Option  : FETCH_SKID_EN - 1-entry skid buffer holds a word returned under stall instead of re-reading it.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   exception,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            PC_out,
    output logic [31:0]            PC_plus4,
    output logic [31:0]            Instruction,
    output logic                   IF_ID_Wr,
    output logic                   IF_ID_Flush
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    // Low for the first cycle after reset release so that nothing is requested
    // or written while reset is (or was just) asserted.
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_pend_target;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_mem_done;

`ifdef FETCH_SKID_EN
    logic        r_skid_vld;
    logic [31:0] r_skid_dat;
    logic [31:0] r_skid_pc;
    logic        w_skid_vld_nxt;
    logic [31:0] w_skid_dat_nxt;
    logic [31:0] w_skid_pc_nxt;
`endif

    pc_redirect_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .i_exception     (exception),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

    // A request completes only when it is actually being presented.
    assign w_mem_done     = w_req & imem.imem_ready;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (r_run) begin
`ifdef FETCH_SKID_EN
            if (r_skid_vld) begin
                // No request is outstanding while the buffer is full.
                w_state_nxt = S_FETCH;
            end else begin
`else
            begin
`endif
                case (r_state)
                    S_FETCH, S_WAIT: begin
                        if (w_mem_done) begin
                            w_state_nxt = S_FETCH;
                        end else if (w_redirect) begin
                            w_state_nxt = S_DISCARD;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                    S_DISCARD: begin
                        if (w_mem_done) begin
                            w_state_nxt = S_FETCH;
                        end
                    end
                    default: w_state_nxt = S_FETCH;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- outputs / datapath next values
    always_comb begin
        w_req       = r_run;
        PC_out      = r_pc;
        PC_plus4    = r_pc + 32'd4;
        Instruction = NOP_INSN;
        IF_ID_Wr    = 1'b0;
        IF_ID_Flush = 1'b0;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_target;
`ifdef FETCH_SKID_EN
        w_skid_vld_nxt = r_skid_vld;
        w_skid_dat_nxt = r_skid_dat;
        w_skid_pc_nxt  = r_skid_pc;
        if (r_skid_vld) begin
            w_req    = 1'b0;
            PC_out   = r_skid_pc;
            PC_plus4 = r_skid_pc + 32'd4;
        end
`endif
        if (r_run) begin
            IF_ID_Flush = w_redirect;
`ifdef FETCH_SKID_EN
            if (r_skid_vld) begin
                if (w_redirect) begin
                    w_skid_vld_nxt = 1'b0;
                    w_pc_nxt       = w_target;
                end else if (!stall) begin
                    IF_ID_Wr       = 1'b1;
                    Instruction    = r_skid_dat;
                    w_skid_vld_nxt = 1'b0;
                end
            end else begin
`else
            begin
`endif
                case (r_state)
                    S_FETCH, S_WAIT: begin
                        if (w_redirect) begin
                            // A request that cannot complete now must be drained first;
                            // its data belongs to the squashed path.
                            if (w_mem_done) begin
                                w_pc_nxt = w_target;
                            end else begin
                                w_pend_nxt = w_target;
                            end
                        end else if (w_mem_done && !stall) begin
                            IF_ID_Wr    = 1'b1;
                            Instruction = imem.imem_rdata;
                            w_pc_nxt    = r_pc + 32'd4;
                        end
`ifdef FETCH_SKID_EN
                        else if (w_mem_done && stall) begin
                            w_skid_vld_nxt = 1'b1;
                            w_skid_dat_nxt = imem.imem_rdata;
                            w_skid_pc_nxt  = r_pc;
                            w_pc_nxt       = r_pc + 32'd4;
                        end
`endif
                    end
                    S_DISCARD: begin
                        // The old address stays on the bus; a newer redirect replaces
                        // the pending target.
                        if (w_redirect) begin
                            w_pend_nxt = w_target;
                        end
                        if (w_mem_done) begin
                            w_pc_nxt = w_redirect ? w_target : r_pend_target;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'h0;
        end else begin
            r_run         <= 1'b1;
            r_pc          <= w_pc_nxt;
            r_pend_target <= w_pend_nxt;
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_vld <= 1'b0;
            r_skid_dat <= NOP_INSN;
            r_skid_pc  <= RESET_PC;
        end else begin
            r_skid_vld <= w_skid_vld_nxt;
            r_skid_dat <= w_skid_dat_nxt;
            r_skid_pc  <= w_skid_pc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose : self-checking bench for if_fetch_unit with a scoreboard of expected IF/ID writes/flushes.
// Latency : n/a.
// Backpr. : memory model raises imem_ready only when rdy_en is set.
module tb_if_fetch_unit;

    typedef struct {
        bit          is_flush;
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exception;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic [31:0] Instruction;
    logic        IF_ID_Wr;
    logic        IF_ID_Flush;
    logic        rdy_en;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    if_fetch_unit_if mem_if ();

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign mem_if.imem_ready = mem_if.imem_req & rdy_en;
    assign mem_if.imem_rdata = (mem_if.imem_req & rdy_en) ? insn_of(mem_if.imem_addr) : 32'hDEAD_BEEF;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exception     (exception),
        .imem          (mem_if.master),
        .PC_out        (PC_out),
        .PC_plus4      (PC_plus4),
        .Instruction   (Instruction),
        .IF_ID_Wr      (IF_ID_Wr),
        .IF_ID_Flush   (IF_ID_Flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [31:0] pc);
        exp_t e;
        e.is_flush = 1'b0;
        e.pc       = pc;
        e.insn     = insn_of(pc);
        sb_q.push_back(e);
    endtask

    task automatic push_f();
        exp_t e;
        e.is_flush = 1'b1;
        e.pc       = 32'h0;
        e.insn     = 32'h0;
        sb_q.push_back(e);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            cyc();
            if (mem_if.imem_addr === a) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait_addr: imem_addr %h never reached %h", mem_if.imem_addr, a);
        end
    endtask

    // Monitor: every IF/ID write or flush must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("wr_flush_exclusive", {31'b0, IF_ID_Wr & IF_ID_Flush}, 32'h0);
            if (IF_ID_Wr || IF_ID_Flush) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: wr=%0b flush=%0b pc=%h expected none",
                             IF_ID_Wr, IF_ID_Flush, PC_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("event_is_flush", {31'b0, IF_ID_Flush}, {31'b0, mon_e.is_flush});
                    if (mon_e.is_flush) begin
                        chk("flush_insn_nop", Instruction, 32'h0);
                    end else begin
                        chk("wr_pc_out", PC_out, mon_e.pc);
                        chk("wr_pc_plus4", PC_plus4, mon_e.pc + 32'd4);
                        chk("wr_insn", Instruction, mon_e.insn);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        jump          = 1'b1;   // redirect held during reset must not flush
        jump_target   = 32'h44;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        exception     = 1'b0;
        rdy_en        = 1'b1;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_if.imem_req}, 32'h0);
        chk("rst_addr", mem_if.imem_addr, 32'h0);
        chk("rst_pc_out", PC_out, 32'h0);
        chk("rst_pc_plus4", PC_plus4, 32'h4);
        chk("rst_insn", Instruction, 32'h0);
        chk("rst_wr", {31'b0, IF_ID_Wr}, 32'h0);
        chk("rst_flush", {31'b0, IF_ID_Flush}, 32'h0);
        jump = 1'b0;

        // ---- zero-wait stream
        push_w(32'h0); push_w(32'h4); push_w(32'h8); push_w(32'hC);
        reset = 1'b1;
        cyc();
        chk("first_req", {31'b0, mem_if.imem_req}, 32'h1);
        wait_addr(32'h10);

        // ---- two-cycle stall at 0x10
        stall = 1'b1;
        #1;
        chk("stall1_wr", {31'b0, IF_ID_Wr}, 32'h0);
        chk("stall1_pc", PC_out, 32'h10);
        cyc();
        chk("stall2_wr", {31'b0, IF_ID_Wr}, 32'h0);
        chk("stall2_pc", PC_out, 32'h10);
        cyc();
        push_w(32'h10);
        stall = 1'b0;

        // ---- branch while waiting on 0x20
        push_w(32'h14); push_w(32'h18); push_w(32'h1C);
        wait_addr(32'h20);
        rdy_en = 1'b0;
        cyc();
        push_f();
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        cyc();
        branch_taken = 1'b0;
        chk("discard_addr_a", mem_if.imem_addr, 32'h20);
        chk("discard_req", {31'b0, mem_if.imem_req}, 32'h1);
        cyc();
        chk("discard_addr_b", mem_if.imem_addr, 32'h20);
        push_w(32'h100);
        rdy_en = 1'b1;
        cyc();
        chk("after_branch_addr", mem_if.imem_addr, 32'h100);

        // ---- all redirects together with stall, at pc 0x104
        cyc();
        push_f();
        exception     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        jump          = 1'b1;
        jump_target   = 32'h300;
        stall         = 1'b1;
        #1;
        chk("prio_flush", {31'b0, IF_ID_Flush}, 32'h1);
        chk("prio_wr", {31'b0, IF_ID_Wr}, 32'h0);
        cyc();
        chk("exc_vector_addr", mem_if.imem_addr, 32'h8000_0008);
        exception = 1'b0; branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        push_w(32'h8000_0008);

        // ---- jump to a misaligned top-of-memory target, then wrap
        cyc();
        push_f();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFE;
        cyc();
        jump = 1'b0;
        chk("wrap_addr", mem_if.imem_addr, 32'hFFFF_FFFC);
        push_w(32'hFFFF_FFFC);
        cyc();
        chk("wrapped_addr", mem_if.imem_addr, 32'h0);
        push_w(32'h0);

        // ---- redirect with no data at pc 4, then reset mid-discard
        cyc();
        rdy_en = 1'b0;
        push_f();
        jump        = 1'b1;
        jump_target = 32'h40;
        cyc();
        jump = 1'b0;
        chk("pre_rst_addr", mem_if.imem_addr, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", {31'b0, mem_if.imem_req}, 32'h0);
        chk("midrst_addr", mem_if.imem_addr, 32'h0);
        chk("midrst_wr", {31'b0, IF_ID_Wr}, 32'h0);
        chk("midrst_flush", {31'b0, IF_ID_Flush}, 32'h0);
        push_w(32'h0); push_w(32'h4);
        cyc();
        reset  = 1'b1;
        rdy_en = 1'b1;
        cyc();
        chk("post_rst_req", {31'b0, mem_if.imem_req}, 32'h1);
        chk("post_rst_addr", mem_if.imem_addr, 32'h0);
        cyc();
        cyc();
        rdy_en = 1'b0;
        repeat (3) cyc();
        chk("scoreboard_empty", sb_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
